rf_buf_ctl: RTL

- Arbiter and sequencer for the RF disk controller's 256x12 sector buffer RAM.
- The RAM is single-ported. This block shares it between two requesters:
  - a host side doing random single-word accesses (IOT/maintenance path);
  - a disk side that streams a block of words through an auto-incrementing buffer pointer.
- It issues at most one RAM access per clock and drives the RAM's a/din/ce/we pins directly.

---
 rtl/rf_buf_ctl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rf_buf_ctl.sv
// rf_buf_ctl: shares the single-port 2^AW x DW sector buffer between a host port and a disk port.
// Latency: 2 cycles from a_req/b_strobe to a_ack/b_rdy uncontended, 3 when the other side wins the tie.
// Backpressure: none. The host waits for a_ack. A disk strobe arriving while one is pending is dropped and pulses b_ovr.
// Ports: clk/reset; a_* host single-word access; b_* disk block stream (auto-incrementing pointer);
//        ram_* drive the buffer RAM pins directly (ram_dout is combinational from ram_a).
module rf_buf_ctl #(
  parameter int AW = 8,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_ack,
  output logic [DW-1:0] a_dout,
  input  logic          b_start,
  input  logic          b_dir,
  input  logic [AW:0]   b_count,
  input  logic          b_strobe,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout,
  output logic          b_rdy,
  output logic          b_busy,
  output logic          b_done,
  output logic          b_ovr,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_din,
  output logic          ram_ce,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  // A start count of zero means a full buffer; stored expanded so the
  // block always ends when the remaining count is exactly one.
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

  logic          a_pend;
  logic          a_we_q;
  logic [AW-1:0] a_addr_q;
  logic [DW-1:0] a_din_q;

  logic          b_pend;
  logic          b_dir_q;
  logic [DW-1:0] b_din_q;
  logic [AW-1:0] ptr;
  logic [AW:0]   cnt;

  logic          last_b;   // 1 when the disk side was served most recently
  logic          gnt_a;
  logic          gnt_b;
  logic          b_final;

  // Ties go to whichever side was not served last.
  always_comb begin
    gnt_a = a_pend & (~b_pend | last_b);
    gnt_b = b_pend & ~gnt_a;
  end

  assign b_final = (cnt == (AW+1)'(1));

  always_comb begin
    ram_ce  = 1'b0;
    ram_we  = 1'b0;
    ram_a   = a_addr_q;
    ram_din = a_din_q;
    if (gnt_a) begin
      ram_ce = 1'b1;
      ram_we = a_we_q;
    end else if (gnt_b) begin
      ram_ce  = 1'b1;
      ram_we  = b_dir_q;
      ram_a   = ptr;
      ram_din = b_din_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_pend   <= 1'b0;
      a_we_q   <= 1'b0;
      a_addr_q <= '0;
      a_din_q  <= '0;
      a_ack    <= 1'b0;
      a_dout   <= '0;
      b_pend   <= 1'b0;
      b_dir_q  <= 1'b0;
      b_din_q  <= '0;
      ptr      <= '0;
      cnt      <= '0;
      b_busy   <= 1'b0;
      b_rdy    <= 1'b0;
      b_done   <= 1'b0;
      b_ovr    <= 1'b0;
      b_dout   <= '0;
      last_b   <= 1'b1;
    end else begin
      a_ack  <= gnt_a;
      b_rdy  <= gnt_b;
      b_done <= gnt_b & b_final;
      b_ovr  <= b_strobe & b_pend;

      // A new host request can only be accepted when nothing is pending,
      // so acceptance and service never coincide.
      if (a_req && !a_pend) begin
        a_pend   <= 1'b1;
        a_we_q   <= a_we;
        a_addr_q <= a_addr;
        a_din_q  <= a_din;
      end else if (gnt_a) begin
        a_pend <= 1'b0;
      end

      if (gnt_a) begin
        last_b <= 1'b0;
        if (!a_we_q) a_dout <= ram_dout;
      end

      if (b_strobe && b_busy && !b_pend) begin
        b_pend  <= 1'b1;
        b_din_q <= b_din;
      end else if (gnt_b) begin
        b_pend <= 1'b0;
      end

      if (gnt_b) begin
        last_b <= 1'b1;
        if (!b_dir_q) b_dout <= ram_dout;
        ptr <= ptr + AW'(1);
        cnt <= cnt - (AW+1)'(1);
        if (b_final) b_busy <= 1'b0;
      end

      // Disk service needs b_busy, so it cannot collide with a block start.
      if (b_start && !b_busy) begin
        b_busy  <= 1'b1;
        ptr     <= '0;
        cnt     <= (b_count == '0) ? CNT_FULL : b_count;
        b_dir_q <= b_dir;
      end
    end
  end

endmodule
